// File: rtl/osd_console_ctrl.sv
// osd_console_ctrl: text console feeding the OSD tile map (CR/LF/BS/FF, wrap, scroll, clear).
// The tile-map write port is shared with SPI, which always wins; the controller stalls around it.
module osd_console_ctrl #(
    parameter int         c_chars_x   = 64,
    parameter int         c_chars_y   = 24,
    parameter int         c_addr_bits = 11,
    parameter logic [7:0] c_blank     = 8'h20
) (
    input  logic                         clk_pixel,
    input  logic                         rstn,
    input  logic [7:0]                   i_char,
    input  logic                         i_char_valid,
    output logic                         o_char_ready,
    input  logic                         i_spi_wr,
    input  logic [c_addr_bits-1:0]       i_spi_addr,
    input  logic [7:0]                   i_spi_data,
    output logic                         o_tm_wr,
    output logic [c_addr_bits-1:0]       o_tm_addr,
    output logic [7:0]                   o_tm_data,
    output logic [c_addr_bits-1:0]       o_tm_rd_addr,
    input  logic [7:0]                   i_tm_rd_data,
    output logic [$clog2(c_chars_x)-1:0] o_cursor_x,
    output logic [$clog2(c_chars_y)-1:0] o_cursor_y,
    output logic                         o_busy
);
    localparam int XW = $clog2(c_chars_x);
    localparam int YW = $clog2(c_chars_y);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_SRD  = 3'd2;
    localparam logic [2:0] S_SWR  = 3'd3;
    localparam logic [2:0] S_SCLR = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;
    localparam logic [c_addr_bits-1:0] A_ROW  = c_addr_bits'(c_chars_x);
    localparam logic [c_addr_bits-1:0] A_LAST = c_addr_bits'(c_chars_x * c_chars_y - 1);
    localparam logic [c_addr_bits-1:0] A_LROW = c_addr_bits'(c_chars_x * (c_chars_y - 1));
    localparam logic [c_addr_bits-1:0] A_ONE  = c_addr_bits'(1);
    localparam logic [XW-1:0] X_MAX = XW'(c_chars_x - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(c_chars_y - 1);

    logic [2:0]             state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [7:0]             ch_q, ch_d;
    logic [c_addr_bits-1:0] cnt_q, cnt_d, cur, wr_addr;
    logic [7:0]             wr_data;
    logic                   wr_en;

    assign cur = c_addr_bits'(y_q) * A_ROW + c_addr_bits'(x_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = cur;
        wr_data = c_blank;
        case (state_q)
            S_IDLE: begin
                if (i_char_valid) begin
                    ch_d    = i_char;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (ch_q == 8'h0D) begin
                    x_d = '0;
                end else if (ch_q == 8'h0C) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CLR;
                end else if (ch_q == 8'h08) begin
                    if (x_q != '0) begin
                        wr_en   = 1'b1;
                        wr_addr = cur - A_ONE;
                        x_d     = x_q - XW'(1);
                    end
                end else begin
                    if (ch_q != 8'h0A) begin
                        wr_en   = 1'b1;
                        wr_data = ch_q;
                        x_d     = (x_q == X_MAX) ? '0 : x_q + XW'(1);
                    end
                    if (ch_q == 8'h0A || x_q == X_MAX) begin
                        if (y_q != Y_MAX) begin
                            y_d = y_q + YW'(1);
                        end else begin
                            cnt_d   = A_ROW;
                            state_d = S_SRD;
                        end
                    end
                end
            end
            S_SRD: state_d = S_SWR;
            S_SWR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q - A_ROW;
                wr_data = i_tm_rd_data;
                cnt_d   = (cnt_q == A_LAST) ? A_LROW : cnt_q + A_ONE;
                state_d = (cnt_q == A_LAST) ? S_SCLR : S_SRD;
            end
            S_SCLR, S_CLR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                cnt_d   = cnt_q + A_ONE;
                state_d = (cnt_q == A_LAST) ? S_IDLE : state_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Any SPI strobe outside IDLE freezes the controller for that cycle, so each costs exactly one cycle.
    always_ff @(posedge clk_pixel) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else if (!(i_spi_wr && state_q != S_IDLE)) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_char_ready = rstn && state_q == S_IDLE;
    assign o_tm_wr      = i_spi_wr || (wr_en && rstn);
    assign o_tm_addr    = i_spi_wr ? i_spi_addr : wr_addr;
    assign o_tm_data    = i_spi_wr ? i_spi_data : wr_data;
    assign o_tm_rd_addr = cnt_q;
    assign o_cursor_x   = x_q;
    assign o_cursor_y   = y_q;
    assign o_busy       = state_q inside {S_SRD, S_SWR, S_SCLR, S_CLR};
endmodule

// File: tb/tb_osd_console_ctrl.sv
// tb_osd_console_ctrl: random console traffic against a queue/array model of the tile map,
// plus directed wrap, backspace, scroll, SPI-stall and clear-abort scenarios.
module tb_osd_console_ctrl;
    localparam int NX = 64;
    localparam int NY = 24;
    localparam int NXY = NX * NY;

    logic        clk_pixel = 1'b0;
    logic        rstn;
    logic [7:0]  i_char;
    logic        i_char_valid;
    logic        o_char_ready;
    logic        i_spi_wr;
    logic [10:0] i_spi_addr;
    logic [7:0]  i_spi_data;
    logic        o_tm_wr;
    logic [10:0] o_tm_addr;
    logic [7:0]  o_tm_data;
    logic [10:0] o_tm_rd_addr;
    logic [7:0]  i_tm_rd_data;
    logic [5:0]  o_cursor_x;
    logic [4:0]  o_cursor_y;
    logic        o_busy;

    logic [7:0] ram [2048];
    logic [7:0] ref_mem [2048];
    logic [7:0] snap [2048];
    int qa[$];
    int qd[$];
    int rx, ry, checks, errors, busy_cnt, spi_mode, pulses, cyc, lc, m;

    osd_console_ctrl dut (
        .clk_pixel(clk_pixel), .rstn(rstn), .i_char(i_char), .i_char_valid(i_char_valid),
        .o_char_ready(o_char_ready), .i_spi_wr(i_spi_wr), .i_spi_addr(i_spi_addr),
        .i_spi_data(i_spi_data), .o_tm_wr(o_tm_wr), .o_tm_addr(o_tm_addr), .o_tm_data(o_tm_data),
        .o_tm_rd_addr(o_tm_rd_addr), .i_tm_rd_data(i_tm_rd_data), .o_cursor_x(o_cursor_x),
        .o_cursor_y(o_cursor_y), .o_busy(o_busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) begin
        if (o_tm_wr) ram[o_tm_addr] <= o_tm_data;
        i_tm_rd_data <= ram[o_tm_rd_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk_pixel) begin
        if (i_spi_wr) begin
            chk("spi_wr", int'(o_tm_wr), 1);
            chk("spi_addr", int'(o_tm_addr), int'(i_spi_addr));
            chk("spi_data", int'(o_tm_data), int'(i_spi_data));
        end else if (!rstn) begin
            chk("rst_wr", int'(o_tm_wr), 0);
        end else if (o_tm_wr) begin
            if (qa.size() == 0) chk("unexpected_wr", int'(o_tm_addr), -1);
            else begin
                chk("wr_addr", int'(o_tm_addr), qa.pop_front());
                chk("wr_data", int'(o_tm_data), qd.pop_front());
            end
        end
        if (!rstn) chk("rst_ready", int'(o_char_ready), 0);
        else if (o_char_ready && !i_char_valid) begin
            chk("cur_x", int'(o_cursor_x), rx);
            chk("cur_y", int'(o_cursor_y), ry);
            chk("idle_busy", int'(o_busy), 0);
        end
        if (o_busy) busy_cnt++;
    end

    task automatic exp_wr(input int a, input int d);
        ref_mem[a] = 8'(d);
        qa.push_back(a);
        qd.push_back(d & 255);
    endtask

    task automatic model_lf();
        if (ry < NY - 1) ry++;
        else begin
            for (int s = NX; s < NXY; s++) exp_wr(s - NX, int'(ref_mem[s]));
            for (int a = NXY - NX; a < NXY; a++) exp_wr(a, 8'h20);
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        case (c)
            8'h0D: rx = 0;
            8'h0A: model_lf();
            8'h08: if (rx > 0) begin rx--; exp_wr(ry * NX + rx, 8'h20); end
            8'h0C: begin
                rx = 0;
                ry = 0;
                for (int a = 0; a < NXY; a++) exp_wr(a, 8'h20);
            end
            default: begin
                exp_wr(ry * NX + rx, int'(c));
                if (rx == NX - 1) begin rx = 0; model_lf(); end
                else rx++;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        i_spi_wr = 1'b0;
        cyc++;
        if ((spi_mode == 1 && $urandom_range(3) == 0) || (spi_mode == 2 && cyc % 3 == 0)) begin
            i_spi_wr   = 1'b1;
            i_spi_addr = (spi_mode == 2) ? 11'd2000 : 11'($urandom_range(2047, NXY));
            i_spi_data = 8'($urandom);
            ref_mem[i_spi_addr] = i_spi_data;
            if (!o_char_ready) pulses++;
        end
    endtask

    task automatic send_byte(input logic [7:0] c, output int low);
        int n = 0;
        while (!o_char_ready && n < 20000) begin tick(); n++; end
        if (!o_char_ready) chk("ready_timeout", 0, 1);
        i_char = c;
        i_char_valid = 1'b1;
        model_byte(c);
        tick();
        i_char_valid = 1'b0;
        low = 0;
        while (!o_char_ready && low < 20000) begin tick(); low++; end
        if (!o_char_ready) chk("busy_timeout", 0, 1);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        rx = 0;
        ry = 0;
        qa.delete();
        qd.delete();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic preload();
        for (int a = 0; a < 2048; a++) begin
            tick();
            i_spi_wr = 1'b1;
            i_spi_addr = 11'(a);
            i_spi_data = 8'(a);
            ref_mem[a] = 8'(a);
        end
        tick();
    endtask

    task automatic mem_cmp(input string nm);
        int bad = 0;
        for (int a = 0; a < 2048; a++) if (ram[a] !== ref_mem[a]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic scroll_test(input int mode);
        int low, bad;
        reset_dut();
        preload();
        for (int i = 0; i < NY - 1; i++) send_byte(8'h0A, low);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), low);
        pulses = 0;
        cyc = 0;
        spi_mode = mode;
        send_byte(8'h0A, low);
        spi_mode = 0;
        tick();
        chk("scroll_len", low, 3009 + pulses);
        bad = 0;
        for (int a = 0; a < NXY - NX; a++) if (ram[a] != 8'(a + 64)) bad++;
        chk("scroll_copy", bad, 0);
        bad = 0;
        for (int a = NXY - NX; a < NXY; a++) if (ram[a] != 8'h20) bad++;
        chk("scroll_blank", bad, 0);
        chk("scroll_x", int'(o_cursor_x), 3);
        chk("scroll_y", int'(o_cursor_y), 23);
        mem_cmp("scroll_mem");
    endtask

    initial begin
        rstn = 1'b0;
        i_char = '0;
        i_char_valid = 1'b0;
        i_spi_wr = 1'b0;
        i_spi_addr = '0;
        i_spi_data = '0;
        {checks, errors, busy_cnt, spi_mode, pulses, cyc} = '0;
        reset_dut();
        chk("rst_cur_x", int'(o_cursor_x), 0);
        chk("rst_cur_y", int'(o_cursor_y), 0);
        chk("rst_rd_addr", int'(o_tm_rd_addr), 0);
        chk("rst_busy", int'(o_busy), 0);
        preload();

        send_byte(8'h41, lc);
        chk("A_low", lc, 1);
        chk("A_ram", int'(ram[0]), 8'h41);
        send_byte(8'h42, lc);
        chk("B_low", lc, 1);
        chk("B_ram", int'(ram[1]), 8'h42);
        chk("AB_x", int'(o_cursor_x), 2);
        chk("AB_y", int'(o_cursor_y), 0);

        send_byte(8'h0D, lc);
        for (int i = 0; i < 5; i++) send_byte(8'h0A, lc);
        for (int i = 0; i < NX; i++) send_byte(8'h78, lc);
        chk("wrap_ram", int'(ram[383]), 8'h78);
        chk("wrap_x", int'(o_cursor_x), 0);
        chk("wrap_y", int'(o_cursor_y), 6);

        reset_dut();
        for (int i = 0; i < 4; i++) send_byte(8'h0A, lc);
        send_byte(8'h08, lc);
        chk("bs0_x", int'(o_cursor_x), 0);
        chk("bs0_y", int'(o_cursor_y), 4);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(126, 33)), lc);
        send_byte(8'h08, lc);
        chk("bs_ram", int'(ram[265]), 8'h20);
        chk("bs_x", int'(o_cursor_x), 9);
        chk("bs_y", int'(o_cursor_y), 4);

        spi_mode = 1;
        for (int i = 0; i < 200; i++) begin
            int r = int'($urandom_range(99));
            send_byte(r < 70 ? 8'($urandom_range(126, 33)) : r < 80 ? 8'h0D :
                      r < 88 ? 8'h0A : r < 98 ? 8'h08 : 8'h0C, lc);
        end
        spi_mode = 0;
        tick();
        chk("rand_queue", qa.size(), 0);
        mem_cmp("rand_mem");

        scroll_test(0);
        scroll_test(2);

        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(126, 33)), lc);
        snap = ref_mem;
        i_char = 8'h0C;
        i_char_valid = 1'b1;
        model_byte(8'h0C);
        tick();
        i_char_valid = 1'b0;
        tick();
        chk("ff_busy", int'(o_busy), 1);
        repeat (100) tick();
        rstn = 1'b0;
        ref_mem = snap;
        for (int a = 0; a < 100; a++) ref_mem[a] = 8'h20;
        qa.delete();
        qd.delete();
        tick();
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_x", int'(o_cursor_x), 0);
        chk("abort_y", int'(o_cursor_y), 0);
        chk("abort_rd_addr", int'(o_tm_rd_addr), 0);
        rstn = 1'b1;
        tick();
        m = 0;
        for (int a = 0; a < 100; a++) if (ram[a] != 8'h20) m++;
        chk("abort_cleared", m, 0);
        m = 0;
        for (int a = 100; a < NXY; a++) if (ram[a] != snap[a]) m++;
        chk("abort_kept", m, 0);

        busy_cnt = 0;
        send_byte(8'h0C, lc);
        chk("clear_busy", busy_cnt, 1536);
        chk("clear_low", lc, 1537);
        tick();
        chk("final_queue", qa.size(), 0);
        mem_cmp("final_mem");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
